onehot_pulse_decoder: RTL

//  Binary-to-one-hot decoder: the reverse direction of our 8-to-3 priority encoder.

---
 rtl/onehot_dec_pkg.sv | 25 ++
 rtl/onehot_pulse_decoder_hold_counter.sv | 41 ++++
 rtl/onehot_pulse_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types, default parameters and the binary-to-one-hot helper for the
// one-hot pulse decoder.
package onehot_dec_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   localparam int DEF_CODE_W  = 3;
   localparam int DEF_NUM_OUT = 8;
   localparam int DEF_HOLD_W  = 4;

   // Widest code the helper supports; callers cast the result down to NUM_OUT.
   localparam int MAX_CODE_W = 8;
   localparam int MAX_OUT    = 1 << MAX_CODE_W;

   function automatic logic [MAX_OUT-1:0] bin2onehot(input logic [MAX_CODE_W-1:0] code);
      logic [MAX_OUT-1:0] v;
      v       = '0;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/onehot_pulse_decoder_hold_counter.sv
// Loadable down-counter that times how long the active one-hot line is held.
// Stops at zero; last flags the final hold cycle.
module hold_counter
#(
   parameter int HOLD_W = 4
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   output logic [HOLD_W-1:0] cnt,
   output logic              last
);

   logic [HOLD_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - HOLD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == HOLD_W'(1));

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Binary-to-one-hot decoder: accepts a code over valid/ready and drives the
// matching line for a programmable number of cycles; out-of-range codes pulse err.
module onehot_pulse_decoder
   import onehot_dec_pkg::*;
#(
   parameter int CODE_W  = DEF_CODE_W,
   parameter int NUM_OUT = DEF_NUM_OUT,
   parameter int HOLD_W  = DEF_HOLD_W
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CODE_W-1:0]  in_code,
   input  logic [HOLD_W-1:0]  hold_cycles,
   output logic [NUM_OUT-1:0] y,
   output logic               busy,
   output logic               done,
   output logic               err
);

   // Handshake: a code transfers on a rising edge where in_valid && in_ready;
   // in_code/hold_cycles are sampled only then, and in_valid may stay high.
   localparam logic [CODE_W:0] NUM_OUT_W = (CODE_W+1)'(NUM_OUT);

   state_t             state_q, state_d;
   logic [NUM_OUT-1:0] y_q, y_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               in_range;
   logic               cnt_load;
   logic               cnt_last;
   logic [HOLD_W-1:0]  cnt;
   logic [HOLD_W-1:0]  hold_eff;
   logic [NUM_OUT-1:0] code_onehot;

   assign in_ready    = !clr && ((state_q == IDLE) || cnt_last);
   assign xfer        = in_valid && in_ready;
   assign in_range    = ({1'b0, in_code} < NUM_OUT_W);
   assign hold_eff    = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
   assign code_onehot = NUM_OUT'(bin2onehot(MAX_CODE_W'(in_code)));

   hold_counter #(.HOLD_W(HOLD_W)) u_hold_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (cnt_load),
      .load_val (hold_eff),
      .cnt      (cnt),
      .last     (cnt_last)
   );

   // done is registered, so it is raised on the edge that makes cnt reach 1.
   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      if (clr) begin
         state_d = IDLE;
         y_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  if (in_range) begin
                     state_d  = DRIVE;
                     y_d      = code_onehot;
                     cnt_load = 1'b1;
                     done_d   = (hold_eff == HOLD_W'(1));
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            DRIVE: begin
               if (cnt_last) begin
                  if (xfer && in_range) begin
                     y_d      = code_onehot;
                     cnt_load = 1'b1;
                     done_d   = (hold_eff == HOLD_W'(1));
                  end else begin
                     state_d = IDLE;
                     y_d     = '0;
                     err_d   = xfer;
                  end
               end else begin
                  done_d = (cnt == HOLD_W'(2));
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         y_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign y    = y_q;
   assign busy = (state_q == DRIVE);
   assign done = done_q;
   assign err  = err_q;

endmodule
